// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects, load-use and MDU stalls,
// and a countdown tracker for the multi-cycle multiply/divide unit.
module hazard_scoreboard #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic             useRsD,
    input  logic             useRtD,
    input  logic             mfhiD,
    input  logic             mfloD,
    input  logic             multD,
    input  logic             divD,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             loadE,
    input  logic             loadM,
    input  logic             multE,
    input  logic             divE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic [1:0]       forwarda,
    output logic [1:0]       forwardb,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [5:0]       mdu_cnt,
    output logic             err_restart
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    mdu_state_t state;
    logic       mdu_start;
    logic       mdu_reader;
    logic       load_use_stall;
    logic       mdu_stall;
    logic       rs_hits_load;
    logic       rt_hits_load;

    // A load in E is not forwardable yet, so it falls through to the M check.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             use_src,
        input logic [REG_W-1:0] dst_e,
        input logic             wr_e,
        input logic             ld_e,
        input logic [REG_W-1:0] dst_m,
        input logic             wr_m,
        input logic             ld_m
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != '0)) begin
            if (wr_e && !ld_e && (src == dst_e)) begin
                sel = 2'b01;
            end else if (wr_m && (src == dst_m)) begin
                sel = ld_m ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        forwarda = fwd_sel(rsD, useRsD, WriteRegE, regwriteE, loadE,
                           WriteRegM, regwriteM, loadM);
        forwardb = fwd_sel(rtD, useRtD, WriteRegE, regwriteE, loadE,
                           WriteRegM, regwriteM, loadM);
    end

    assign rs_hits_load   = useRsD && (rsD == WriteRegE);
    assign rt_hits_load   = useRtD && (rtD == WriteRegE);
    assign load_use_stall = loadE && regwriteE && (WriteRegE != '0)
                            && (rs_hits_load || rt_hits_load);

    assign mdu_start  = multE || divE;
    assign mdu_reader = mfhiD || mfloD || multD || divD;
    assign mdu_busy   = (state == BUSY);
    assign mdu_stall  = mdu_reader && (mdu_busy || mdu_start);

    assign stallF = load_use_stall || mdu_stall;
    assign stallD = load_use_stall || mdu_stall;
    assign flushE = load_use_stall || mdu_stall;

    // Counter reaches 1 on the last busy cycle; done is the registered
    // hand-off, so it lands in the first IDLE cycle with busy already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mdu_cnt     <= '0;
            mdu_done    <= 1'b0;
            err_restart <= 1'b0;
        end else begin
            mdu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state   <= BUSY;
                        mdu_cnt <= divE ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (mdu_start) begin
                        err_restart <= 1'b1;
                    end
                    if (mdu_cnt == 6'd1) begin
                        state    <= IDLE;
                        mdu_done <= 1'b1;
                    end
                    mdu_cnt <= mdu_cnt - 6'd1;
                end
                default: begin
                    state   <= IDLE;
                    mdu_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared against a cycle-indexed reference of MDU operations.
module tb_hazard_scoreboard;

    localparam int REG_W   = 5;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REG_W-1:0] rsD, rtD, WriteRegE, WriteRegM;
    logic             useRsD, useRtD, mfhiD, mfloD, multD, divD;
    logic             regwriteE, regwriteM, loadE, loadM, multE, divE;
    logic             stallF, stallD, flushE, mdu_busy, mdu_done, err_restart;
    logic [1:0]       forwarda, forwardb;
    logic [5:0]       mdu_cnt;

    hazard_scoreboard #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .mfhiD(mfhiD), .mfloD(mfloD), .multD(multD), .divD(divD),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
        .regwriteE(regwriteE), .regwriteM(regwriteM),
        .loadE(loadE), .loadM(loadM), .multE(multE), .divE(divE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwarda(forwarda), .forwardb(forwardb),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_cnt(mdu_cnt),
        .err_restart(err_restart)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: the single accepted MDU op started at cycle op_start
    // (-1 = none) with latency op_lat; the cycle number is cyc.
    int cyc = 0;
    int op_start = -1;
    int op_lat = 0;
    bit err_model = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit ref_busy(input int c);
        return (op_start >= 0) && (c > op_start) && (c < op_start + op_lat);
    endfunction

    function automatic int ref_cnt(input int c);
        return ref_busy(c) ? (op_start + op_lat - c) : 0;
    endfunction

    function automatic bit ref_done(input int c);
        return (op_start >= 0) && (c == op_start + op_lat);
    endfunction

    function automatic int ref_fwd(input logic [REG_W-1:0] src, input logic use_src);
        if (!use_src || src == 0) return 0;
        if (regwriteE && !loadE && src == WriteRegE) return 1;
        if (regwriteM && src == WriteRegM) return loadM ? 3 : 2;
        return 0;
    endfunction

    function automatic bit ref_stall();
        bit lu, md;
        lu = loadE && regwriteE && (WriteRegE != 0)
             && ((useRsD && rsD == WriteRegE) || (useRtD && rtD == WriteRegE));
        md = (mfhiD || mfloD || multD || divD)
             && ((rst_n && ref_busy(cyc)) || multE || divE);
        return lu || md;
    endfunction

    task automatic check_all();
        bit st;
        st = ref_stall();
        check("forwarda", forwarda, ref_fwd(rsD, useRsD));
        check("forwardb", forwardb, ref_fwd(rtD, useRtD));
        check("stallF", stallF, st);
        check("stallD", stallD, st);
        check("flushE", flushE, st);
        check("mdu_busy", mdu_busy, rst_n ? ref_busy(cyc) : 0);
        check("mdu_cnt", mdu_cnt, rst_n ? ref_cnt(cyc) : 0);
        check("mdu_done", mdu_done, rst_n ? ref_done(cyc) : 0);
        check("err_restart", err_restart, err_model);
    endtask

    // Advance one clock, updating the reference from the inputs held across
    // the edge; returns 1 ns after the edge with inputs free to change.
    task automatic tick();
        @(posedge clk);
        if (rst_n && (multE || divE)) begin
            if (ref_busy(cyc)) begin
                err_model = 1'b1;
            end else begin
                op_start = cyc;
                op_lat   = divE ? DIV_LAT : MUL_LAT;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; WriteRegE = '0; WriteRegM = '0;
        useRsD = 0; useRtD = 0; mfhiD = 0; mfloD = 0; multD = 0; divD = 0;
        regwriteE = 0; regwriteM = 0; loadE = 0; loadM = 0; multE = 0; divE = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        op_start = -1;
        err_model = 1'b0;
        // Combinational paths must stay live while reset is held.
        rsD = 5'd7; useRsD = 1; WriteRegM = 5'd7; regwriteM = 1; loadM = 1;
        mfloD = 1; multE = 1;
        #1 check_all();
        tick();
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #2 check_all();
    endtask

    initial begin
        clear_inputs();
        #3;
        check("reset_busy", mdu_busy, 0);
        check("reset_cnt", mdu_cnt, 0);
        check("reset_done", mdu_done, 0);
        check("reset_err", err_restart, 0);
        apply_reset();

        // ALU op in E forwards to rs, ALU op in M forwards to rt.
        tick();
        WriteRegE = 5'd3; regwriteE = 1; WriteRegM = 5'd4; regwriteM = 1;
        rsD = 5'd3; rtD = 5'd4; useRsD = 1; useRtD = 1;
        #2 check_all();
        check("alu_fwda", forwarda, 1);
        check("alu_fwdb", forwardb, 2);
        check("alu_nostall", stallD, 0);

        // lw $5 in E with a dependent reader: one stall, then load data from M.
        tick(); clear_inputs();
        WriteRegE = 5'd5; regwriteE = 1; loadE = 1; rsD = 5'd5; useRsD = 1;
        #2 check_all();
        check("lu_stall", stallF, 1);
        tick(); clear_inputs();
        WriteRegM = 5'd5; regwriteM = 1; loadM = 1; rsD = 5'd5; useRsD = 1;
        #2 check_all();
        check("lu_fwda", forwarda, 3);
        check("lu_released", stallD, 0);

        // Writes to register 0 never forward or stall.
        tick(); clear_inputs();
        WriteRegE = 5'd0; regwriteE = 1; loadE = 1; rsD = 5'd0; useRsD = 1;
        #2 check_all();
        check("r0_fwda", forwarda, 0);
        check("r0_nostall", flushE, 0);

        // Unused source never forwards even on a match.
        tick(); clear_inputs();
        WriteRegE = 5'd9; regwriteE = 1; rtD = 5'd9; useRtD = 0;
        #2 check_all();
        check("unused_fwdb", forwardb, 0);

        // mult in E with mflo waiting in D.
        tick(); clear_inputs();
        multE = 1; mfloD = 1;
        #2 check_all();
        check("mul_stall_start", stallF, 1);
        for (int k = 1; k <= 3; k++) begin
            tick(); multE = 0;
            #2 check_all();
            check("mul_cnt", mdu_cnt, 4 - k);
            check("mul_stall", stallF, 1);
        end
        tick();
        #2 check_all();
        check("mul_done", mdu_done, 1);
        check("mul_done_busy", mdu_busy, 0);
        check("mul_done_stall", stallF, 0);
        tick(); mfloD = 0;
        #2 check_all();
        check("mul_done_pulse", mdu_done, 0);

        // div, then a restart attempt while busy.
        tick(); clear_inputs();
        divE = 1;
        #2 check_all();
        tick(); divE = 0;
        #2 check_all();
        tick(); divE = 1;
        #2 check_all();
        tick(); divE = 0;
        #2 check_all();
        check("restart_cnt", mdu_cnt, DIV_LAT - 3);
        check("restart_err", err_restart, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            #2 check_all();
        end
        check("restart_err_hold", err_restart, 1);

        // Reset mid-division at count 17: abort, no done pulse.
        while (mdu_cnt != 6'd17 && ref_cnt(cyc) > 0) begin
            tick();
            #2 check_all();
        end
        check("abort_at17", mdu_cnt, 17);
        rst_n = 1'b0;
        op_start = -1;
        err_model = 1'b0;
        #1;
        check("abort_busy", mdu_busy, 0);
        check("abort_cnt", mdu_cnt, 0);
        check("abort_err", err_restart, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            #2 check_all();
        end

        // Random traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (n % 500 == 499) begin
                apply_reset();
                continue;
            end
            rsD = REG_W'($urandom_range(0, 7));
            rtD = REG_W'($urandom_range(0, 7));
            WriteRegE = REG_W'($urandom_range(0, 7));
            WriteRegM = REG_W'($urandom_range(0, 7));
            useRsD = 1'($urandom); useRtD = 1'($urandom);
            regwriteE = 1'($urandom); regwriteM = 1'($urandom);
            loadE = 1'($urandom); loadM = 1'($urandom);
            mfhiD = ($urandom_range(0, 7) == 0); mfloD = ($urandom_range(0, 7) == 0);
            multD = ($urandom_range(0, 15) == 0); divD = ($urandom_range(0, 15) == 0);
            multE = ($urandom_range(0, 19) == 0); divE = ($urandom_range(0, 29) == 0);
            #2 check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
